// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection (stall, branch, jump, call, jr, ret)
// with a circular return-address stack for call/return.
module pc_sequencer #(
    parameter int              PC_W      = 32,
    parameter int              IMM_W     = 6,
    parameter int              JADDR_W   = 12,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         branch,
    input  logic                         branch_ne,
    input  logic                         alu_zero,
    input  logic [IMM_W-1:0]             imm,
    input  logic                         jump,
    input  logic                         call,
    input  logic [JADDR_W-1:0]           jump_target,
    input  logic                         ret,
    input  logic                         jr,
    input  logic [PC_W-1:0]              jr_target,
    output logic [PC_W-1:0]              pc,
    output logic [PC_W-1:0]              pc_plus_1,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow,
    output logic                         redirected
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;   // next free slot; top of stack is ras_ptr-1

    logic [PC_W-1:0]  imm_ext;
    logic [PC_W-1:0]  branch_target;
    logic [PC_W-1:0]  jump_addr;
    logic [PC_W-1:0]  ras_top;
    logic             taken;
    logic             ras_empty;
    logic             ras_full;

    logic [PC_W-1:0]  next_pc;
    logic             do_push;
    logic             do_pop;
    logic             next_redirected;
    logic             set_underflow;

    assign pc_plus_1     = pc + PC_W'(1);
    assign imm_ext       = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign branch_target = pc_plus_1 + imm_ext;
    assign jump_addr     = {pc_plus_1[PC_W-1:JADDR_W], jump_target};
    assign taken         = (branch & alu_zero) | (branch_ne & ~alu_zero);
    assign ras_top       = ras_mem[ras_ptr - PTR_W'(1)];
    assign ras_empty     = (ras_count == '0);
    assign ras_full      = (ras_count == CNT_W'(RAS_DEPTH));

    // Priority chain: only the winning request produces side effects.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        next_pc         = pc_plus_1;
        do_push         = 1'b0;
        do_pop          = 1'b0;
        next_redirected = 1'b0;
        set_underflow   = 1'b0;
        if (ret) begin
            if (!ras_empty) begin
                next_pc         = ras_top;
                do_pop          = 1'b1;
                next_redirected = 1'b1;
            end else begin
                set_underflow   = 1'b1;
            end
        end else if (jr) begin
            next_pc         = jr_target;
            next_redirected = 1'b1;
        end else if (call) begin
            next_pc         = jump_addr;
            do_push         = 1'b1;
            next_redirected = 1'b1;
        end else if (jump) begin
            next_pc         = jump_addr;
            next_redirected = 1'b1;
        end else if (taken) begin
            next_pc         = branch_target;
            next_redirected = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc            <= RESET_PC;
            ras_ptr       <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            redirected    <= 1'b0;
        end else if (!stall) begin
            pc         <= next_pc;
            redirected <= next_redirected;
            if (do_push) begin
                ras_ptr <= ras_ptr + PTR_W'(1);
                if (ras_full) begin
                    ras_overflow <= 1'b1;
                end else begin
                    ras_count <= ras_count + CNT_W'(1);
                end
            end
            if (do_pop) begin
                ras_ptr   <= ras_ptr - PTR_W'(1);
                ras_count <= ras_count - CNT_W'(1);
            end
            if (set_underflow) begin
                ras_underflow <= 1'b1;
            end
        end
    end

    // NOTE: stack storage has no reset; entries beyond ras_count are never read.
    always_ff @(posedge clock) begin
        if (!reset && !stall && do_push) begin
            ras_mem[ras_ptr] <= pc_plus_1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// stimulus compared against a queue-based reference model.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch;
    logic        branch_ne;
    logic        alu_zero;
    logic [5:0]  imm;
    logic        jump;
    logic        call;
    logic [11:0] jump_target;
    logic        ret;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus_1;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;
    logic        redirected;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_over;
    logic        m_under;
    logic        m_redir;

    pc_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch        (branch),
        .branch_ne     (branch_ne),
        .alu_zero      (alu_zero),
        .imm           (imm),
        .jump          (jump),
        .call          (call),
        .jump_target   (jump_target),
        .ret           (ret),
        .jr            (jr),
        .jr_target     (jr_target),
        .pc            (pc),
        .pc_plus_1     (pc_plus_1),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow),
        .redirected    (redirected)
    );

    always #5 clock = ~clock;

    task automatic idle_inputs();
        reset = 1'b0; stall = 1'b0; branch = 1'b0; branch_ne = 1'b0;
        alu_zero = 1'b0; imm = '0; jump = 1'b0; call = 1'b0;
        jump_target = '0; ret = 1'b0; jr = 1'b0; jr_target = '0;
    endtask

    // Model applies the architectural rules to the inputs present before the edge.
    task automatic model_step();
        logic [31:0] p1;
        logic [31:0] off;
        p1  = m_pc + 32'd1;
        off = 32'(int'($signed(imm)));
        if (reset) begin
            m_pc = 32'd0; m_ras.delete(); m_over = 0; m_under = 0; m_redir = 0;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (ret) begin
            if (m_ras.size() > 0) begin
                m_pc = m_ras.pop_back(); m_redir = 1;
            end else begin
                m_pc = p1; m_under = 1; m_redir = 0;
            end
        end else if (jr) begin
            m_pc = jr_target; m_redir = 1;
        end else if (call) begin
            if (m_ras.size() == 4) begin
                void'(m_ras.pop_front());
                m_over = 1;
            end
            m_ras.push_back(p1);
            m_pc = {p1[31:12], jump_target}; m_redir = 1;
        end else if (jump) begin
            m_pc = {p1[31:12], jump_target}; m_redir = 1;
        end else if ((branch && alu_zero) || (branch_ne && !alu_zero)) begin
            m_pc = p1 + off; m_redir = 1;
        end else begin
            m_pc = p1; m_redir = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic goto_pc(input logic [31:0] target);
        idle_inputs();
        jr = 1'b1; jr_target = target;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (pc !== 32'd0 || ras_count !== 3'd0 || ras_overflow !== 1'b0 ||
            ras_underflow !== 1'b0 || redirected !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got pc=%0h cnt=%0d ov=%b un=%b rd=%b expected pc=0 cnt=0 flags=0",
                     pc, ras_count, ras_overflow, ras_underflow, redirected);
        end
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (pc !== 32'(i) || pc_plus_1 !== 32'(i + 1) || ras_count !== 3'd0 || redirected !== 1'b0) begin
                errors++;
                $display("FAIL free_run_%0d: got pc=%0h pc1=%0h cnt=%0d rd=%b expected pc=%0h",
                         i, pc, pc_plus_1, ras_count, redirected, i);
            end
        end
    endtask

    task automatic test_branch();
        goto_pc(32'd10);
        branch = 1'b1; alu_zero = 1'b1; imm = 6'b111110;
        tick(); idle_inputs();
        checks++;
        if (pc !== 32'd9 || redirected !== 1'b1) begin
            errors++;
            $display("FAIL beq_taken: got pc=%0h rd=%b expected pc=9 rd=1", pc, redirected);
        end
        goto_pc(32'd10);
        branch = 1'b1; alu_zero = 1'b0; imm = 6'b111110;
        tick(); idle_inputs();
        checks++;
        if (pc !== 32'd11 || redirected !== 1'b0) begin
            errors++;
            $display("FAIL beq_not_taken: got pc=%0h rd=%b expected pc=b rd=0", pc, redirected);
        end
        goto_pc(32'd10);
        branch_ne = 1'b1; alu_zero = 1'b0; imm = 6'd5;
        tick(); idle_inputs();
        checks++;
        if (pc !== 32'd16 || redirected !== 1'b1) begin
            errors++;
            $display("FAIL bne_taken: got pc=%0h rd=%b expected pc=10 rd=1", pc, redirected);
        end
    endtask

    task automatic test_call_ret();
        goto_pc(32'h0000_1005);
        call = 1'b1; jump_target = 12'h020;
        tick(); idle_inputs();
        checks++;
        if (pc !== 32'h0000_1020 || ras_count !== 3'd1 || redirected !== 1'b1) begin
            errors++;
            $display("FAIL call: got pc=%0h cnt=%0d expected pc=1020 cnt=1", pc, ras_count);
        end
        ret = 1'b1;
        tick(); idle_inputs();
        checks++;
        if (pc !== 32'h0000_1006 || ras_count !== 3'd0 || redirected !== 1'b1) begin
            errors++;
            $display("FAIL ret: got pc=%0h cnt=%0d expected pc=1006 cnt=0", pc, ras_count);
        end
    endtask

    task automatic test_overflow();
        goto_pc(32'd1);
        for (int i = 1; i <= 5; i++) begin
            call = 1'b1; jump_target = 12'(i + 1);
            tick();
        end
        idle_inputs();
        checks++;
        if (pc !== 32'd6 || ras_count !== 3'd4 || ras_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ras_overflow: got pc=%0h cnt=%0d ov=%b expected pc=6 cnt=4 ov=1",
                     pc, ras_count, ras_overflow);
        end
        for (int i = 0; i < 4; i++) begin
            ret = 1'b1;
            tick();
            checks++;
            if (pc !== 32'(6 - i) || ras_count !== 3'(3 - i)) begin
                errors++;
                $display("FAIL ras_pop_%0d: got pc=%0h cnt=%0d expected pc=%0h cnt=%0d",
                         i, pc, ras_count, 6 - i, 3 - i);
            end
        end
        tick(); idle_inputs();
        checks++;
        if (pc !== 32'd4 || ras_underflow !== 1'b1 || redirected !== 1'b0 || ras_count !== 3'd0) begin
            errors++;
            $display("FAIL ras_underflow: got pc=%0h un=%b rd=%b cnt=%0d expected pc=4 un=1 rd=0 cnt=0",
                     pc, ras_underflow, redirected, ras_count);
        end
    endtask

    task automatic test_stall_conflict();
        goto_pc(32'h200);
        call = 1'b1; jump_target = 12'h100;
        tick();
        stall = 1'b1; jump_target = 12'h300;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc !== 32'h100 || ras_count !== 3'd1 || redirected !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold_%0d: got pc=%0h cnt=%0d rd=%b expected pc=100 cnt=1 rd=1",
                         i, pc, ras_count, redirected);
            end
        end
        stall = 1'b0; ret = 1'b1;
        tick(); idle_inputs();
        checks++;
        if (pc !== 32'h201 || ras_count !== 3'd0) begin
            errors++;
            $display("FAIL call_ret_conflict: got pc=%0h cnt=%0d expected pc=201 cnt=0", pc, ras_count);
        end
    endtask

    task automatic test_reset_mid_stack();
        goto_pc(32'h50);
        for (int i = 0; i < 3; i++) begin
            call = 1'b1; jump_target = 12'(12'h60 + 12'(16 * i));
            tick();
        end
        idle_inputs();
        checks++;
        if (ras_count !== 3'd3) begin
            errors++;
            $display("FAIL mid_stack_fill: got cnt=%0d expected cnt=3", ras_count);
        end
        reset = 1'b1;
        tick(); idle_inputs();
        checks++;
        if (pc !== 32'd0 || ras_count !== 3'd0 || ras_overflow !== 1'b0 ||
            ras_underflow !== 1'b0 || redirected !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stack: got pc=%0h cnt=%0d ov=%b un=%b rd=%b expected all 0",
                     pc, ras_count, ras_overflow, ras_underflow, redirected);
        end
        ret = 1'b1;
        tick(); idle_inputs();
        checks++;
        if (pc !== 32'd1 || ras_underflow !== 1'b1) begin
            errors++;
            $display("FAIL stack_discarded: got pc=%0h un=%b expected pc=1 un=1", pc, ras_underflow);
        end
    endtask

    task automatic test_wrap();
        goto_pc(32'hFFFF_FFFF);
        checks++;
        if (pc_plus_1 !== 32'd0) begin
            errors++;
            $display("FAIL pc_plus_1_wrap: got %0h expected 0", pc_plus_1);
        end
        tick();
        checks++;
        if (pc !== 32'd0 || redirected !== 1'b0) begin
            errors++;
            $display("FAIL pc_wrap: got pc=%0h rd=%b expected pc=0 rd=0", pc, redirected);
        end
        goto_pc(32'hFFFF_FFFE);
        branch = 1'b1; alu_zero = 1'b1; imm = 6'd1;
        tick(); idle_inputs();
        checks++;
        if (pc !== 32'd0 || redirected !== 1'b1) begin
            errors++;
            $display("FAIL branch_wrap: got pc=%0h rd=%b expected pc=0 rd=1", pc, redirected);
        end
    endtask

    task automatic test_random();
        idle_inputs();
        reset = 1'b1;
        tick();
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 59) == 0);
            stall       = ($urandom_range(0, 7) == 0);
            branch      = ($urandom_range(0, 3) == 0);
            branch_ne   = ($urandom_range(0, 3) == 0);
            alu_zero    = 1'($urandom);
            imm         = 6'($urandom);
            jump        = ($urandom_range(0, 7) == 0);
            call        = ($urandom_range(0, 4) == 0);
            jump_target = 12'($urandom);
            ret         = ($urandom_range(0, 4) == 0);
            jr          = ($urandom_range(0, 9) == 0);
            jr_target   = $urandom;
            tick();
            checks++;
            if (pc !== m_pc || pc_plus_1 !== m_pc + 32'd1 || ras_count !== 3'(m_ras.size()) ||
                ras_overflow !== m_over || ras_underflow !== m_under || redirected !== m_redir) begin
                errors++;
                $display("FAIL random_%0d: got pc=%0h cnt=%0d ov=%b un=%b rd=%b expected pc=%0h cnt=%0d ov=%b un=%b rd=%b",
                         n, pc, ras_count, ras_overflow, ras_underflow, redirected,
                         m_pc, m_ras.size(), m_over, m_under, m_redir);
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_pc = '0; m_over = 0; m_under = 0; m_redir = 0;
        idle_inputs();
        test_reset();
        test_branch();
        test_call_ret();
        test_overflow();
        test_stall_conflict();
        test_reset_mid_stack();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
